// File: rtl/ethernet_depackager.sv
// Receive-side Ethernet depackager: locks onto preamble+SFD in an MSB-first dibit stream,
// parses and filters the header, and emits payload bytes one per valid pulse.
module ethernet_depackager #(
    parameter logic [47:0] MY_MAC           = 48'hF00DDEADBEEF,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter int unsigned MIN_PREAMBLE     = 16,
    parameter int unsigned MAX_PAYLOAD      = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [7:0]  axiod,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic [10:0] byte_count
);

    localparam int unsigned PRE_W      = 5;
    localparam int unsigned HDR_W      = 6;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned HDR_BITS   = 112;
    localparam int unsigned HDR_DIBITS = HDR_BITS / 2;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        HEADER,
        PAYLOAD,
        DROP
    } state_t;

    state_t                  state, state_d;
    logic [PRE_W-1:0]        pre_cnt, pre_cnt_d;
    logic [1:0]              sfd_cnt, sfd_cnt_d;
    logic [HDR_W-1:0]        hdr_cnt, hdr_cnt_d;
    logic [HDR_BITS-3:0]     hdr_sr, hdr_sr_d;
    logic [1:0]              phase, phase_d;
    logic [5:0]              byte_sr, byte_sr_d;
    logic                    axiov_d, frame_start_d, frame_done_d, frame_err_d;
    logic [7:0]              axiod_d;
    logic [47:0]             src_mac_d;
    logic [15:0]             ethertype_d;
    logic [CNT_W-1:0]        byte_count_d;

    // Header as it stands once the current dibit is shifted in
    logic [HDR_BITS-1:0]     full_hdr;
    logic                    dest_ok;

    assign full_hdr = {hdr_sr, axiid};
    assign dest_ok  = (full_hdr[111:64] == MY_MAC) ||
                      (ACCEPT_BROADCAST && (full_hdr[111:64] == 48'hFFFF_FFFF_FFFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DROP;
            pre_cnt     <= '0;
            sfd_cnt     <= '0;
            hdr_cnt     <= '0;
            hdr_sr      <= '0;
            phase       <= '0;
            byte_sr     <= '0;
            axiov       <= 1'b0;
            axiod       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            src_mac     <= '0;
            ethertype   <= '0;
            byte_count  <= '0;
        end else begin
            state       <= state_d;
            pre_cnt     <= pre_cnt_d;
            sfd_cnt     <= sfd_cnt_d;
            hdr_cnt     <= hdr_cnt_d;
            hdr_sr      <= hdr_sr_d;
            phase       <= phase_d;
            byte_sr     <= byte_sr_d;
            axiov       <= axiov_d;
            axiod       <= axiod_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
            frame_err   <= frame_err_d;
            src_mac     <= src_mac_d;
            ethertype   <= ethertype_d;
            byte_count  <= byte_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        pre_cnt_d     = pre_cnt;
        sfd_cnt_d     = sfd_cnt;
        hdr_cnt_d     = hdr_cnt;
        hdr_sr_d      = hdr_sr;
        phase_d       = phase;
        byte_sr_d     = byte_sr;
        axiov_d       = 1'b0;
        axiod_d       = axiod;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        src_mac_d     = src_mac;
        ethertype_d   = ethertype;
        byte_count_d  = byte_count;

        case (state)
            DROP: begin
                if (!axiiv) state_d = IDLE;
            end
            IDLE: begin
                if (axiiv) begin
                    if (axiid == 2'b01) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!axiiv) begin
                    state_d = IDLE;
                end else if (axiid == 2'b01) begin
                    if (pre_cnt != '1) pre_cnt_d = pre_cnt + PRE_W'(1);
                end else if (axiid == 2'b11 && pre_cnt >= PRE_W'(MIN_PREAMBLE)) begin
                    state_d   = SFD;
                    sfd_cnt_d = '0;
                end else begin
                    state_d = DROP;
                end
            end
            // The leading 11 of 8'hD5 was taken in PREAMBLE; three 01 dibits remain
            SFD: begin
                if (!axiiv) begin
                    state_d = IDLE;
                end else if (axiid == 2'b01) begin
                    if (sfd_cnt == 2'd2) begin
                        state_d   = HEADER;
                        hdr_cnt_d = '0;
                    end else begin
                        sfd_cnt_d = sfd_cnt + 2'd1;
                    end
                end else begin
                    state_d = DROP;
                end
            end
            HEADER: begin
                if (!axiiv) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    hdr_sr_d = full_hdr[HDR_BITS-3:0];
                    if (hdr_cnt == HDR_W'(HDR_DIBITS - 1)) begin
                        if (dest_ok) begin
                            state_d       = PAYLOAD;
                            src_mac_d     = full_hdr[63:16];
                            ethertype_d   = full_hdr[15:0];
                            byte_count_d  = '0;
                            frame_start_d = 1'b1;
                            phase_d       = '0;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt + HDR_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (!axiiv) begin
                    state_d = IDLE;
                    if (phase == 2'd0 && byte_count != '0) frame_done_d = 1'b1;
                    else                                   frame_err_d  = 1'b1;
                end else begin
                    byte_sr_d = {byte_sr[3:0], axiid};
                    phase_d   = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (byte_count == CNT_W'(MAX_PAYLOAD)) begin
                            state_d     = DROP;
                            frame_err_d = 1'b1;
                        end else begin
                            axiov_d      = 1'b1;
                            axiod_d      = {byte_sr, axiid};
                            byte_count_d = byte_count + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = DROP;
        endcase
    end

endmodule

// File: tb/tb_ethernet_depackager.sv
// Scoreboard bench for ethernet_depackager: frames are driven as dibits, expected payload
// bytes are queued as they are sent and matched against axiov/axiod.
module tb_ethernet_depackager;

    localparam logic [47:0] MY_MAC = 48'hF00DDEADBEEF;
    localparam logic [47:0] SRC    = 48'h0123456789AB;
    localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'b00;

    logic        axiov, frame_start, frame_done, frame_err;
    logic [7:0]  axiod;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [10:0] byte_count;

    logic        nb_axiov, nb_frame_start, nb_frame_done, nb_frame_err;
    logic [7:0]  nb_axiod;
    logic [47:0] nb_src_mac;
    logic [15:0] nb_ethertype;
    logic [10:0] nb_byte_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] pay [$];

    int n_axiov = 0, n_start = 0, n_done = 0, n_err = 0;
    int nb_n_axiov = 0, nb_n_start = 0, nb_n_err = 0;
    int cyc = 0, last_axiov_cyc = 0, last_gap = 0;

    ethernet_depackager dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .frame_start(frame_start),
        .frame_done(frame_done), .frame_err(frame_err),
        .src_mac(src_mac), .ethertype(ethertype), .byte_count(byte_count)
    );

    ethernet_depackager #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
        .axiov(nb_axiov), .axiod(nb_axiod), .frame_start(nb_frame_start),
        .frame_done(nb_frame_done), .frame_err(nb_frame_err),
        .src_mac(nb_src_mac), .ethertype(nb_ethertype), .byte_count(nb_byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on every payload byte and counts pulses
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (axiov) begin
            n_axiov++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL axiod_unexpected got %02h required no byte", axiod);
            end else begin
                exp_b = exp_q.pop_front();
                if (axiod !== exp_b) begin
                    errors++;
                    $display("FAIL axiod got %02h required %02h", axiod, exp_b);
                end
            end
            last_gap       = cyc - last_axiov_cyc;
            last_axiov_cyc = cyc;
        end
        if (frame_start) n_start++;
        if (frame_done)  n_done++;
        if (frame_err)   n_err++;
        if (32'(axiov) + 32'(frame_start) + 32'(frame_done) + 32'(frame_err) > 1) begin
            errors++;
            $display("FAIL pulse_overlap got v%0b s%0b d%0b e%0b required at most one",
                     axiov, frame_start, frame_done, frame_err);
        end
        if (nb_axiov)       nb_n_axiov++;
        if (nb_frame_start) nb_n_start++;
        if (nb_frame_err)   nb_n_err++;
    end

    task automatic drive_dibit(input logic [1:0] d);
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            axiiv = 1'b0;
            axiid = 2'b00;
        end
    endtask

    // Sends one frame using pay[] as payload; rst_at >= 0 pulses rst_n at that payload dibit
    task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ,
                              input int pre_len, input int n_dib,
                              input bit accept, input int rst_at);
        logic [111:0] hdr;
        logic [7:0]   b;
        bit           acc;
        hdr = {dest, SRC, typ};
        acc = accept;
        for (int i = 0; i < pre_len; i++) drive_dibit(2'b01);
        drive_dibit(2'b11);
        for (int i = 0; i < 3; i++) drive_dibit(2'b01);
        for (int i = 0; i < 56; i++) drive_dibit(hdr[111-2*i -: 2]);
        for (int k = 0; k < n_dib; k++) begin
            b = pay[k/4];
            drive_dibit(b[7-2*(k%4) -: 2]);
            if (k == rst_at) begin
                rst_n = 1'b0;
                acc   = 1'b0;
            end else if (k == rst_at + 1) begin
                rst_n = 1'b1;
            end
            if (acc && (k % 4 == 3) && (k / 4 < 1500)) exp_q.push_back(b);
        end
        idle_cycles(4);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #23;
        checks++;
        if ({axiov, frame_start, frame_done, frame_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got %04b required 0000",
                     {axiov, frame_start, frame_done, frame_err});
        end
        checks++;
        if ({axiod, src_mac, ethertype, byte_count} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h required zeros",
                     axiod, src_mac, ethertype, byte_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_basic;
        int s0, v0, d0, e0;
        s0 = n_start; v0 = n_axiov; d0 = n_done; e0 = n_err;
        pay = '{8'hA5, 8'h3C};
        send_frame(MY_MAC, 16'h0800, 28, 8, 1'b1, -1);
        checks++;
        if ({n_start - s0, n_axiov - v0, n_done - d0, n_err - e0} !== {32'd1, 32'd2, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL basic_pulses got s%0d v%0d d%0d e%0d required s1 v2 d1 e0",
                     n_start - s0, n_axiov - v0, n_done - d0, n_err - e0);
        end
        checks++;
        if (last_gap !== 4) begin
            errors++;
            $display("FAIL basic_byte_gap got %0d required 4", last_gap);
        end
        checks++;
        if (byte_count !== 11'd2) begin
            errors++;
            $display("FAIL basic_byte_count got %0d required 2", byte_count);
        end
        checks++;
        if (src_mac !== SRC || ethertype !== 16'h0800) begin
            errors++;
            $display("FAIL basic_header got %h/%h required %h/0800", src_mac, ethertype, SRC);
        end
    endtask

    task automatic test_dest_filter;
        int s0, v0, e0, d0;
        s0 = n_start; v0 = n_axiov; e0 = n_err; d0 = n_done;
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(48'h0A0B0C0D0E0F, 16'h0800, 28, 12, 1'b0, -1);
        checks++;
        if ({n_start - s0, n_axiov - v0, n_err - e0} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL filter_drop got s%0d v%0d e%0d required zeros",
                     n_start - s0, n_axiov - v0, n_err - e0);
        end
        send_frame(MY_MAC, 16'h86DD, 28, 12, 1'b1, -1);
        checks++;
        if (n_done - d0 !== 1 || n_axiov - v0 !== 3 || byte_count !== 11'd3 || ethertype !== 16'h86DD) begin
            errors++;
            $display("FAIL filter_next got d%0d v%0d bc%0d type %h required d1 v3 bc3 86dd",
                     n_done - d0, n_axiov - v0, byte_count, ethertype);
        end
    endtask

    task automatic test_broadcast;
        int s0, v0, ns0, nv0, ne0;
        s0 = n_start; v0 = n_axiov; ns0 = nb_n_start; nv0 = nb_n_axiov; ne0 = nb_n_err;
        pay = '{8'h5A, 8'hC3};
        send_frame(BCAST, 16'h0806, 20, 8, 1'b1, -1);
        checks++;
        if (n_start - s0 !== 1 || n_axiov - v0 !== 2) begin
            errors++;
            $display("FAIL bcast_accept got s%0d v%0d required s1 v2", n_start - s0, n_axiov - v0);
        end
        checks++;
        if (nb_n_start - ns0 !== 0 || nb_n_axiov - nv0 !== 0 || nb_n_err - ne0 !== 0
            || nb_byte_count !== 11'd3) begin
            errors++;
            $display("FAIL bcast_reject got s%0d v%0d e%0d bc%0d required s0 v0 e0 bc3",
                     nb_n_start - ns0, nb_n_axiov - nv0, nb_n_err - ne0, nb_byte_count);
        end
    endtask

    task automatic test_truncated;
        int v0, d0, e0;
        v0 = n_axiov; d0 = n_done; e0 = n_err;
        pay = '{8'hDE, 8'hAD, 8'hBE};
        send_frame(MY_MAC, 16'h0800, 28, 10, 1'b1, -1);
        checks++;
        if ({n_axiov - v0, n_done - d0, n_err - e0} !== {32'd2, 32'd0, 32'd1} || byte_count !== 11'd2) begin
            errors++;
            $display("FAIL truncated got v%0d d%0d e%0d bc%0d required v2 d0 e1 bc2",
                     n_axiov - v0, n_done - d0, n_err - e0, byte_count);
        end
    endtask

    task automatic test_preamble;
        int s0, e0;
        pay = '{8'h77};
        for (int p = 10; p <= 16; p += 5) begin
            s0 = n_start; e0 = n_err;
            send_frame(MY_MAC, 16'h0800, p, 4, 1'b0, -1);
            checks++;
            if (n_start - s0 !== 0 || n_err - e0 !== 0) begin
                errors++;
                $display("FAIL short_preamble_%0d got s%0d e%0d required s0 e0",
                         p, n_start - s0, n_err - e0);
            end
        end
        s0 = n_start;
        send_frame(MY_MAC, 16'h0800, 16, 4, 1'b1, -1);
        checks++;
        if (n_start - s0 !== 1 || byte_count !== 11'd1) begin
            errors++;
            $display("FAIL min_preamble got s%0d bc%0d required s1 bc1", n_start - s0, byte_count);
        end
    endtask

    task automatic test_oversize;
        int v0, d0, e0;
        pay.delete();
        for (int i = 0; i < 1501; i++) pay.push_back(8'(i * 37 + 5));
        v0 = n_axiov; d0 = n_done; e0 = n_err;
        send_frame(MY_MAC, 16'h0800, 20, 1501 * 4, 1'b1, -1);
        checks++;
        if ({n_axiov - v0, n_done - d0, n_err - e0} !== {32'd1500, 32'd0, 32'd1} || byte_count !== 11'd1500) begin
            errors++;
            $display("FAIL oversize got v%0d d%0d e%0d bc%0d required v1500 d0 e1 bc1500",
                     n_axiov - v0, n_done - d0, n_err - e0, byte_count);
        end
        v0 = n_axiov; d0 = n_done; e0 = n_err;
        send_frame(MY_MAC, 16'h0800, 20, 1500 * 4, 1'b1, -1);
        checks++;
        if ({n_axiov - v0, n_done - d0, n_err - e0} !== {32'd1500, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL max_payload got v%0d d%0d e%0d required v1500 d1 e0",
                     n_axiov - v0, n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_reset_mid;
        int v0, d0, e0, s0;
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'(8'h40 + i));
        v0 = n_axiov; d0 = n_done; e0 = n_err;
        send_frame(MY_MAC, 16'h0800, 28, 40, 1'b1, 22);
        checks++;
        if ({n_axiov - v0, n_done - d0, n_err - e0} !== {32'd5, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid got v%0d d%0d e%0d required v5 d0 e0",
                     n_axiov - v0, n_done - d0, n_err - e0);
        end
        checks++;
        if (byte_count !== 11'd0 || src_mac !== 48'd0) begin
            errors++;
            $display("FAIL reset_mid_clear got bc%0d src %h required 0", byte_count, src_mac);
        end
        s0 = n_start; d0 = n_done;
        pay = '{8'hF1, 8'hE2};
        send_frame(MY_MAC, 16'h0801, 28, 8, 1'b1, -1);
        checks++;
        if (n_start - s0 !== 1 || n_done - d0 !== 1 || byte_count !== 11'd2) begin
            errors++;
            $display("FAIL reset_resume got s%0d d%0d bc%0d required s1 d1 bc2",
                     n_start - s0, n_done - d0, byte_count);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = n_done;
        pay = '{8'h01, 8'h02};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 28; j++) drive_dibit(2'b01);
            drive_dibit(2'b11);
            for (int j = 0; j < 3; j++) drive_dibit(2'b01);
            for (int j = 0; j < 56; j++) drive_dibit({MY_MAC, SRC, 16'h0800} >> (110 - 2 * j));
            for (int k = 0; k < 8; k++) begin
                drive_dibit(pay[k/4] >> (6 - 2 * (k % 4)));
                if (k % 4 == 3) exp_q.push_back(pay[k/4]);
            end
            idle_cycles(1);
        end
        idle_cycles(4);
        checks++;
        if (n_done - d0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back got d%0d pending %0d required d3 pending 0",
                     n_done - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_dest_filter;
        test_broadcast;
        test_truncated;
        test_preamble;
        test_oversize;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
